channel_pack_4x16: RTL and testbench

CHANNEL_PACK_4X16 -- requirements
Module: channel_pack_4x16

---
 rtl/channel_pack_4x16.sv | 111 +++++++++++
 tb/tb_channel_pack_4x16.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_pack_4x16.sv
// Packs NCH consecutive channel slices into one wide output word, with a
// one-word output register that keeps accepting slices while it is stalled.
module channel_pack_4x16 #(
  parameter int LANE_W = 11,
  parameter int LANES  = 16,
  parameter int NCH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANE_W*LANES-1:0]       in_data,
  input  logic                          in_first,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANE_W*LANES*NCH-1:0]   out_data,
  output logic                          err_align,
  output logic [15:0]                   word_cnt
);

  localparam int SW = LANE_W * LANES;
  localparam int WW = SW * NCH;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BN = (NCH > 1) ? NCH - 1 : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  logic [CW-1:0]          ch_idx_q, ch_idx_d;
  logic [BN-1:0][SW-1:0]  asm_q, asm_d;
  logic                   out_valid_q, out_valid_d;
  logic [WW-1:0]          out_data_q, out_data_d;
  logic                   err_align_q, err_align_d;
  logic [15:0]            word_cnt_q, word_cnt_d;

  logic          accept;
  logic          deliver;
  logic          completes;
  logic [CW-1:0] pos;
  logic [WW-1:0] word;

  // Only the completing slice can be blocked; earlier positions overlap the drain.
  assign in_ready = !((ch_idx_q == LAST) && out_valid_q && !out_ready);

  always_comb begin
    accept    = in_valid && in_ready;
    deliver   = out_valid_q && out_ready;
    pos       = in_first ? '0 : ch_idx_q;
    completes = accept && (pos == LAST);

    word = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      word[k*SW +: SW] = asm_q[k];
    end
    word[(NCH-1)*SW +: SW] = in_data;

    ch_idx_d    = ch_idx_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_align_d = err_align_q;
    word_cnt_d  = word_cnt_q;

    if (accept) begin
      ch_idx_d = completes ? '0 : pos + CW'(1);
      if ((in_first && ch_idx_q != '0) || (!in_first && ch_idx_q == '0)) begin
        err_align_d = 1'b1;
      end
    end

    for (int k = 0; k < BN; k++) begin
      if (accept && !completes && pos == CW'(k)) begin
        asm_d[k] = in_data;
      end
    end

    // A completion on the same edge as a delivery reloads without a bubble.
    if (completes) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    if (deliver) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_idx_q    <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_align_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      ch_idx_q    <= ch_idx_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_align_q <= err_align_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_align = err_align_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_channel_pack_4x16.sv
// Bench for channel_pack_4x16: vector table, hand-built corner sequences and
// a queue scoreboard that follows every accepted slice and delivered word.
module tb_channel_pack_4x16;

  localparam int LANE_W = 11;
  localparam int LANES  = 16;
  localparam int NCH    = 4;
  localparam int SW     = LANE_W * LANES;
  localparam int WW     = SW * NCH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_data;
  logic          in_first;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic          err_align;
  logic [15:0]   word_cnt;

  always #5 clk = ~clk;

  channel_pack_4x16 #(.LANE_W(LANE_W), .LANES(LANES), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_align(err_align),
    .word_cnt(word_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] d, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    while (!in_ready) begin
      if (n >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck 0 after %0d cycles, required 1", n);
        break;
      end
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [SW-1:0] mk_slice(input logic [LANE_W-1:0] v);
    logic [SW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = v;
    return r;
  endfunction

  // Expected word laid out lane by lane: channel k, lane i at (k*LANES+i)*LANE_W.
  function automatic logic [WW-1:0] exp_word(input logic [3:0][LANE_W-1:0] v);
    logic [WW-1:0] r;
    for (int k = 0; k < NCH; k++)
      for (int i = 0; i < LANES; i++)
        r[(k*LANES+i)*LANE_W +: LANE_W] = v[k];
    return r;
  endfunction

  // Scoreboard reference state.
  logic [WW-1:0] sb_q[$];
  logic [SW-1:0] asm_m [3];
  int            ch_m;
  int            pos_m;
  logic [15:0]   wcnt_m;
  logic          err_m;
  logic          prev_stall;
  logic [WW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      ch_m       = 0;
      wcnt_m     = 16'd0;
      err_m      = 1'b0;
      prev_stall = 1'b0;
      for (int k = 0; k < 3; k++) asm_m[k] = '0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", WW'(out_valid), WW'(1));
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        chk("sb_word_cnt", WW'(word_cnt), WW'(wcnt_m));
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: word %0h delivered, none expected", out_data);
        end else begin
          chk("sb_word", out_data, sb_q.pop_front());
        end
        wcnt_m = wcnt_m + 16'd1;
      end
      if (in_valid && in_ready) begin
        chk("sb_err_align", WW'(err_align), WW'(err_m));
        pos_m = in_first ? 0 : ch_m;
        if ((in_first && ch_m != 0) || (!in_first && ch_m == 0)) err_m = 1'b1;
        if (pos_m == NCH - 1) begin
          sb_q.push_back({in_data, asm_m[2], asm_m[1], asm_m[0]});
          ch_m = 0;
        end else begin
          asm_m[pos_m] = in_data;
          ch_m = pos_m + 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  typedef struct packed {
    logic [3:0][SW-1:0] sl;
    logic [WW-1:0]      exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [LANE_W-1:0]        lv;
    logic [3:0][LANE_W-1:0]   v;
    logic [WW-1:0]            w1, w2;

    for (int e = 0; e < 5; e++)
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < LANES; i++) begin
          case (e)
            0: lv = LANE_W'(k*16 + i);
            1: lv = 11'h7FF;
            2: lv = i[0] ? 11'h3FF : 11'h400;
            3: lv = (i[0] ^ k[0]) ? 11'h555 : 11'h2AA;
            default: lv = LANE_W'($urandom);
          endcase
          tbl[e].sl[k][i*LANE_W +: LANE_W]           = lv;
          tbl[e].exp[(k*LANES+i)*LANE_W +: LANE_W]   = lv;
        end

    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", WW'(in_ready), WW'(1));
    chk("rst_out_valid", WW'(out_valid), WW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_word_cnt", WW'(word_cnt), WW'(0));
    chk("rst_err", WW'(err_align), WW'(0));
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", WW'(in_ready), WW'(1));

    // Basic word A0..A3.
    for (int k = 0; k < 4; k++) send(mk_slice(LANE_W'(11'h0A0 + k)), k == 0);
    chk("a_valid", WW'(out_valid), WW'(1));
    chk("a_data", out_data, exp_word({11'h0A3, 11'h0A2, 11'h0A1, 11'h0A0}));
    chk("a_err", WW'(err_align), WW'(0));
    step();
    chk("a_word_cnt", WW'(word_cnt), WW'(1));
    chk("a_drained", WW'(out_valid), WW'(0));

    // Table of words streamed back-to-back.
    for (int e = 0; e < 5; e++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1;
        in_data  = tbl[e].sl[k];
        in_first = (k == 0);
        chk("stream_in_ready", WW'(in_ready), WW'(1));
        step();
      end
      chk("tbl_valid", WW'(out_valid), WW'(1));
      chk("tbl_data", out_data, tbl[e].exp);
    end
    in_valid = 1'b0;
    step();
    chk("tbl_word_cnt", WW'(word_cnt), WW'(6));

    // Stalled output: positions 0..2 accepted, completing slice held off.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(mk_slice(LANE_W'(11'h100 + k)), k == 0);
    w1 = exp_word({11'h103, 11'h102, 11'h101, 11'h100});
    w2 = exp_word({11'h203, 11'h202, 11'h201, 11'h200});
    chk("stall_w1_valid", WW'(out_valid), WW'(1));
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = mk_slice(LANE_W'(11'h200 + k)); in_first = (k == 0);
      chk("stall_overlap_ready", WW'(in_ready), WW'(1));
      step();
    end
    in_valid = 1'b1; in_data = mk_slice(11'h203); in_first = 1'b0;
    #1;
    chk("stall_block_ready", WW'(in_ready), WW'(0));
    repeat (3) begin
      step();
      chk("stall_block_ready", WW'(in_ready), WW'(0));
      chk("stall_w1_hold", out_data, w1);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", WW'(in_ready), WW'(1));
    step();
    chk("stall_w2_valid", WW'(out_valid), WW'(1));
    chk("stall_w2_data", out_data, w2);
    in_valid = 1'b0;
    step();
    chk("stall_word_cnt", WW'(word_cnt), WW'(8));
    chk("stall_drained", WW'(out_valid), WW'(0));

    // Misplaced in_first on the third slice restarts the word.
    send(mk_slice(11'h300), 1'b1);
    send(mk_slice(11'h301), 1'b0);
    send(mk_slice(11'h302), 1'b1);
    chk("realign_err", WW'(err_align), WW'(1));
    send(mk_slice(11'h303), 1'b0);
    send(mk_slice(11'h304), 1'b0);
    send(mk_slice(11'h305), 1'b0);
    chk("realign_valid", WW'(out_valid), WW'(1));
    chk("realign_data", out_data, exp_word({11'h305, 11'h304, 11'h303, 11'h302}));
    step();
    chk("realign_word_cnt", WW'(word_cnt), WW'(9));

    // Reset with a pending word and a partial word.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(mk_slice(LANE_W'(11'h400 + k)), (k % 4) == 0);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", WW'(out_valid), WW'(0));
    chk("mid_rst_word_cnt", WW'(word_cnt), WW'(0));
    chk("mid_rst_err", WW'(err_align), WW'(0));
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_in_ready", WW'(in_ready), WW'(1));
    rst = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(mk_slice(LANE_W'(11'h500 + k)), k == 0);
    chk("clean_valid", WW'(out_valid), WW'(1));
    chk("clean_data", out_data, exp_word({11'h503, 11'h502, 11'h501, 11'h500}));
    chk("clean_err", WW'(err_align), WW'(0));
    step();
    chk("clean_word_cnt", WW'(word_cnt), WW'(1));

    // First beat after reset without in_first still lands at position 0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(mk_slice(LANE_W'(11'h600 + k)), 1'b0);
      if (k == 0) chk("nofirst_err", WW'(err_align), WW'(1));
    end
    chk("nofirst_valid", WW'(out_valid), WW'(1));
    chk("nofirst_data", out_data, exp_word({11'h603, 11'h602, 11'h601, 11'h600}));
    step();
    chk("nofirst_word_cnt", WW'(word_cnt), WW'(1));

    step(); step();
    chk("sb_empty", WW'(sb_q.size()), WW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
